// File: rtl/serial_frame_tx_if.sv
// Parallel load channel for serial_frame_tx: a byte plus a valid/ready handshake.
// The master offers in_data/in_valid; the slave (transmitter) answers with in_ready.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/serial_frame_tx.sv
// UART-style frame serialiser paced by an external, asynchronous bit clock.
// Each rising edge of the synchronised bit clock is one bit tick; every line
// level is held for exactly one tick-to-tick interval. Frame layout on tx_out:
// start (0), DATA_W data bits LSB first, optional parity, STOP_BITS stop bits (1).
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_clk_in,
  serial_frame_tx_if.slave  bus,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_e;

  // Parity of a data word; odd parity is the inverted even parity.
  function automatic logic parity_of(input logic [DATA_W-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                par_q, par_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                prev_q, prev_d;
  logic                tick_s;
  logic                accept_s;
  logic                stop_last_s;

  assign tick_s       = sync2_q & ~prev_q;
  assign accept_s     = bus.in_valid & ready_q;
  assign stop_last_s  = (STOP_BITS == 1) || stop_cnt_q;

  assign bus.in_ready = ready_q;
  assign tx_out       = tx_q;
  assign tx_busy      = busy_q;
  assign frame_done   = done_q;

  // Next-state and next-output logic; everything past IDLE advances only on a tick.
  always_comb begin
    sync1_d    = bit_clk_in;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    par_d      = par_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (accept_s) begin
          shift_d = bus.in_data;
          par_d   = parity_of(bus.in_data);
          busy_d  = 1'b1;
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        // Waiting here aligns the start bit to a tick boundary.
        if (tick_s) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end else begin
          tx_d    = 1'b1;
        end
      end
      S_START: begin
        if (tick_s) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (tick_s) begin
          if (idx_q == IDX_LAST) begin
            stop_cnt_d = 1'b0;
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            shift_d = {1'b0, shift_q[DATA_W-1:1]};
            tx_d    = shift_q[1];
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (tick_s) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end else begin
          state_d    = S_PARITY;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (tick_s) begin
          if (stop_last_s) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Ready is a registered copy of "will be in IDLE", so it rises with frame_done.
    ready_d = (state_d == S_IDLE);
  end

  // Synchroniser, FSM and datapath registers with immediate reset to the idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
    end
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Downstream consumer of the divided bit clock. Synchronises the slow clock, detects its rising edges, and uses each edge as a bit tick. Serialises parallel bytes into UART-style frames (start bit, data LSB-first, optional parity, stop bits) on one output line toward the external instrument link. Parallel data is loaded through a valid/ready handshake.

Parameters:
DATA_W, 8, data bits per frame (5..9).
PARITY_EN, 1, 1 inserts a parity bit after the data bits; 0 omits it.
PARITY_ODD, 0, 0 gives even parity; 1 gives odd parity. Ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
clk  input  1  system clock, 100 MHz.
rst  input  1  asynchronous reset, active-high.
bit_clk_in  input  1  divided bit clock, square wave; asynchronous to the logic and synchronised internally.
in_data  input  DATA_W  byte to transmit.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept a byte.
tx_out  output  1  serial line; idles high.
tx_busy  output  1  frame is in progress.
frame_done  output  1  one-clk pulse at the end of each frame.

Behaviour:
- Reset values: tx_out=1, tx_busy=0, in_ready=0, frame_done=0, state=IDLE, sync/edge flops=0. Reset takes effect immediately, including mid-frame. After reset, tx_out returns high and the partial frame is discarded.
- in_ready rises on the first clk edge after rst deasserts. It is registered and is 1 only in IDLE.
- Tick generation:
  - Two-flop synchroniser on bit_clk_in, plus a previous-value flop.
  - tick = sync2 & ~prev, a single-clk pulse.
  - Latency from a bit_clk_in rising edge to tick is 2–3 clk.
  - Falling edges are ignored.
- Handshake:
  - A byte is accepted on the clk edge where in_valid & in_ready.
  - On acceptance: capture in_data into the shift register, compute parity, set in_ready=0 and tx_busy=1, go to ARMED.
  - in_data is don't-care after acceptance. in_valid while not ready is held off (no loss, no latch).
- State machine. All transitions except IDLE→ARMED occur only on clk cycles with tick=1. tx_out is registered and changes the cycle after the tick.
  - IDLE: tx_out=1. Accepts a byte and goes to ARMED.
  - ARMED: tx_out=1. On tick, go to START with tx_out=0. This aligns the frame start to a tick boundary.
  - START: on tick, go to DATA with tx_out=shift[0] and bit index=0.
  - DATA: on each tick, shift right and increment the index.
    - After bit DATA_W-1 has been held for one tick period, go to PARITY (tx_out=parity) if PARITY_EN, else to STOP (tx_out=1).
  - PARITY: on tick, go to STOP with tx_out=1.
    - Parity = XOR(data), inverted when PARITY_ODD=1.
  - STOP: hold tx_out=1 for STOP_BITS tick periods.
    - On the tick that ends the last stop bit: frame_done=1 for one clk, tx_busy=0, in_ready=1, go to IDLE.
- Each bit is held for exactly one tick-to-tick interval.
- Frame length in ticks from START entry to frame_done: 1 + DATA_W + PARITY_EN + STOP_BITS.
- Back-to-back frames:
  - A byte offered the cycle in_ready rises is accepted next edge and waits in ARMED for the following tick.
  - So at least one full idle-high bit period separates frames.
- A tick arriving on the same clk as acceptance is not used by ARMED; the next tick starts the frame.
- bit_clk_in stuck (no edges): the FSM holds its current state indefinitely; there is no timeout.
- Bit index counter is $clog2(DATA_W+1) bits wide and never wraps past DATA_W-1.

Test Plan:
1. Reset/idle:
   - Assert rst mid-run → tx_out=1, tx_busy=0, in_ready=0, frame_done=0 immediately.
   - in_ready=1 one clk after release.
2. Basic frame (defaults; bit_clk_in period 20 clk):
   - Send 0xA5 → tx_out sequence over 11 tick periods: 0,1,0,1,0,0,1,0,1,0(parity even),1(stop).
   - frame_done pulses once, one clk wide.
3. Odd parity and two stops (PARITY_ODD=1, STOP_BITS=2):
   - Send 0x07 → data 1,1,1,0,0,0,0,0, parity 0, two stop bits.
   - frame_done 12 ticks after START.
4. Handshake hold-off:
   - Hold in_valid=1 with 0x3C, then change in_data to 0xFF mid-frame → second frame carries 0xFF.
   - The first frame is unaffected.
   - in_ready=0 throughout the first frame.
5. Back-to-back:
   - Keep in_valid high for 3 bytes → exactly one idle-high bit period between frames.
   - No byte dropped or duplicated.
6. Tick edge cases:
   - bit_clk_in glitch-free but stopped for 500 clk mid-DATA → tx_out frozen, resumes correctly.
   - Reset during PARITY → line high, next frame correct.
